// File: rtl/dvr_st_loader.sv
// Byte-serial loader: assembles a sync field and a key field from a framed
// configuration byte stream and presents them as one dvr transaction.
module dvr_st_loader #(
    parameter int DATA_WIDTH_IN_BYTES = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      cfg_byte,
    input  logic                            cfg_valid,
    input  logic                            cfg_sop,
    output logic                            cfg_rdy,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0] dvr_key,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0] dvr_sync,
    output logic                            dvr_valid,
    input  logic                            dvr_rdy,
    output logic                            err
);

    localparam int W8 = DATA_WIDTH_IN_BYTES * 8;
    localparam int CW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH_IN_BYTES - 1);
    // A sop byte fills the whole sync field when fields are one byte wide.
    localparam logic SINGLE = (DATA_WIDTH_IN_BYTES == 1);

    // Handshakes: cfg byte moves when cfg_valid & cfg_rdy; dvr transaction
    // moves when dvr_valid & dvr_rdy. Both ready/valid are state decodes only.
    typedef enum logic [1:0] {
        WAIT_SOP  = 2'd0,
        LOAD_SYNC = 2'd1,
        LOAD_KEY  = 2'd2,
        PRESENT   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W8-1:0]   sync_q, sync_n, key_q, key_n;
    logic            err_q, err_n;
    logic            take;
    logic [W8-1:0]   sync_sh, key_sh;

    assign take    = cfg_valid & cfg_rdy;
    assign sync_sh = (sync_q << 8) | W8'(cfg_byte);
    assign key_sh  = (key_q << 8) | W8'(cfg_byte);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= WAIT_SOP;
            cnt    <= '0;
            sync_q <= '0;
            key_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sync_q <= sync_n;
            key_q  <= key_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sync_n  = sync_q;
        key_n   = key_q;
        err_n   = 1'b0;
        cfg_rdy   = (state != PRESENT);
        dvr_valid = (state == PRESENT);
        case (state)
            WAIT_SOP, LOAD_SYNC, LOAD_KEY: begin
                if (take && cfg_sop) begin
                    // A sop outside WAIT_SOP abandons the partial record.
                    err_n   = (state != WAIT_SOP);
                    sync_n  = sync_sh;
                    cnt_n   = SINGLE ? '0 : CW'(1);
                    state_n = SINGLE ? LOAD_KEY : LOAD_SYNC;
                end else if (take) begin
                    case (state)
                        WAIT_SOP: err_n = 1'b1;
                        LOAD_SYNC: begin
                            sync_n = sync_sh;
                            if (cnt == LAST) begin
                                cnt_n   = '0;
                                state_n = LOAD_KEY;
                            end else begin
                                cnt_n = cnt + CW'(1);
                            end
                        end
                        default: begin
                            key_n = key_sh;
                            if (cnt == LAST) begin
                                cnt_n   = '0;
                                state_n = PRESENT;
                            end else begin
                                cnt_n = cnt + CW'(1);
                            end
                        end
                    endcase
                end
            end
            PRESENT: begin
                if (dvr_rdy) state_n = WAIT_SOP;
            end
            default: state_n = WAIT_SOP;
        endcase
    end

    assign dvr_key  = key_q;
    assign dvr_sync = sync_q;
    assign err      = err_q;

endmodule

// File: doc/dvr_st_loader.md
# dvr_st_loader

Byte-serial loader that assembles a sync pattern and a key from a configuration byte stream. It presents them as one transaction on the dvr stream as master, driving key, sync and valid and receiving rdy. It sits between the configuration/host byte path and the sync-and-key consumer. It holds each sync/key pair until the consumer accepts it, then reopens for the next record.

## Interface
Parameters:
- DATA_WIDTH_IN_BYTES, 16, byte width of key and of sync; W8 = DATA_WIDTH_IN_BYTES*8.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_byte  in  8  configuration data byte.
- cfg_valid  in  1  cfg_byte/cfg_sop valid.
- cfg_sop  in  1  marks first byte of a record (first sync byte).
- cfg_rdy  out  1  loader can accept a byte; byte taken when cfg_valid & cfg_rdy.
- dvr_key  out  W8  assembled key (dvr master key).
- dvr_sync  out  W8  assembled sync (dvr master sync).
- dvr_valid  out  1  key/sync transaction valid.
- dvr_rdy  in  1  consumer accepts; transfer when dvr_valid & dvr_rdy.
- err  out  1  one-cycle pulse on a framing error.

## Operation
- Record format: DATA_WIDTH_IN_BYTES sync bytes, then DATA_WIDTH_IN_BYTES key bytes. The first byte carries cfg_sop=1; all others carry cfg_sop=0.
- Byte order: the first byte of each field ends in bits [W8-1:W8-8]. Each accepted byte shifts in at the LSB: reg <= {reg[W8-9:0], cfg_byte}.
- Byte counter cnt: width $clog2(DATA_WIDTH_IN_BYTES), range 0..DATA_WIDTH_IN_BYTES-1. It is cleared when a field completes.
- States:
  - WAIT_SOP: cfg_rdy=1.
    - Accepted byte with sop=1: shift into sync, cnt=1, go to LOAD_SYNC.
    - Accepted byte with sop=0: byte discarded, err pulse, stay.
  - LOAD_SYNC: cfg_rdy=1.
    - Accepted sop=0 byte: shift into sync, cnt++.
    - On the byte with cnt==DATA_WIDTH_IN_BYTES-1: cnt=0, go to LOAD_KEY.
  - LOAD_KEY: cfg_rdy=1.
    - Accepted sop=0 byte: shift into key, cnt++.
    - On the last byte: cnt=0, go to PRESENT.
  - PRESENT: cfg_rdy=0, dvr_valid=1.
    - On dvr_valid & dvr_rdy: go to WAIT_SOP.
- Restart on sop: an accepted sop=1 byte in LOAD_SYNC or LOAD_KEY pulses err and abandons the partial record. The byte is shifted into sync, cnt=1, and the state goes to LOAD_SYNC.
- Edge case: DATA_WIDTH_IN_BYTES=1 completes each field on its single byte. The sop byte goes directly to LOAD_KEY.
- dvr_key/dvr_sync are driven directly from the assembly registers.
  - They are meaningful only while dvr_valid=1.
  - They must not change while dvr_valid=1.
- cfg_rdy and dvr_valid are decoded combinationally from the state register.
- err is registered.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=WAIT_SOP, cnt=0, key=0, sync=0, err=0, dvr_valid=0.
  - cfg_rdy=1 as soon as reset asserts, because it is decoded from WAIT_SOP.
- Latency: if the last key byte is accepted in cycle N, dvr_valid=1 in cycle N+1.
- Minimum record time: 2*DATA_WIDTH_IN_BYTES byte cycles, plus one cycle in PRESENT when dvr_rdy=1.
- Back-to-back records:
  - A transfer in cycle M gives cfg_rdy=1 in cycle M+1.
  - The next sop byte is accepted in cycle M+1 at the earliest.
- No combinational path from dvr_rdy to cfg_rdy, or from cfg_valid to dvr_valid.
- Backpressure: while dvr_rdy=0 in PRESENT, dvr_valid, dvr_key and dvr_sync hold indefinitely. cfg_rdy=0, so no input is consumed.
- Input gaps: cfg_valid=0 cycles change nothing; cnt and state hold.
- err: a one-cycle pulse in the cycle after the offending byte is accepted.
- Reset mid-record or during PRESENT: dvr_valid drops immediately (asynchronously). The partial record is lost.

## Test plan
- Basic record: W=16, sop byte 0x00, then bytes 0x01..0x1F continuously; dvr_rdy=1.
  - Required: dvr_sync=0x000102...0F, dvr_key=0x101112...1F.
  - dvr_valid high exactly one cycle, starting the cycle after byte 0x1F. cfg_rdy low that cycle. err never pulses.
- Backpressure: same record with dvr_rdy=0 for 5 cycles, then 1.
  - Required: dvr_valid high 6 cycles with key/sync constant. cfg_rdy=0 for those 6 cycles. cfg_valid pulses during them are ignored.
- Missing sop: 3 bytes 0xAA with sop=0 from WAIT_SOP, then a valid record.
  - Required: 3 err pulses, all 3 bytes accepted and discarded. The following record completes with correct values.
- Truncated record: sop record aborted after 7 key bytes by a new sop byte 0x55, then 31 more bytes 0x56..0x74.
  - Required: one err pulse. dvr_sync=0x55..0x64, dvr_key=0x65..0x74. No dvr_valid for the truncated record.
- Back-to-back with gaps:
  - Stimulus: two records, cfg_valid toggling every other cycle, dvr_rdy=1.
  - Required: two dvr_valid single-cycle pulses with the respective values. The second sop is accepted the cycle after the first transfer.
- Async reset: assert rst_n=0 mid-cycle during PRESENT.
  - Required: dvr_valid=0, err=0 and cfg_rdy=1 without waiting for a clock edge. After release, a fresh record loads correctly.
